// File: rtl/rr_arbiter_mux_if.sv
// rr_arbiter_mux_if: requester/consumer bundle for rr_arbiter_mux.
//   slave  modport : arbiter side (receives requests, drives output channel)
//   master modport : environment side (requesters and consumer)
// Signals:
//   i_req_valid [COUNT]       requester k has a payload
//   i_req_data  [WIDTH]x[COUNT] per-requester payload
//   i_req_lock  [COUNT]       requester k asks to keep priority (lock build only)
//   o_req_ready [COUNT]       one-hot/zero accept strobe back to requesters
//   o_valid, o_data, o_grant  registered output channel
//   i_ready                   consumer accepts o_data this cycle
interface rr_arbiter_mux_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned COUNT = 4
);
    logic [COUNT-1:0] i_req_valid;
    logic [WIDTH-1:0] i_req_data [0:COUNT-1];
    logic [COUNT-1:0] i_req_lock;
    logic [COUNT-1:0] o_req_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [COUNT-1:0] o_grant;
    logic             i_ready;

    modport slave (
        input  i_req_valid, i_req_data, i_req_lock, i_ready,
        output o_req_ready, o_valid, o_data, o_grant
    );

    modport master (
        output i_req_valid, i_req_data, i_req_lock, i_ready,
        input  o_req_ready, o_valid, o_data, o_grant
    );
endinterface

// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux: round-robin arbiter sharing one registered output channel
// among COUNT valid/ready requesters. One-hot grant, AND-OR payload mux,
// one-entry output register.
// Ports:
//   i_clk  clock, all state on rising edge
//   i_rst  synchronous active-high reset
//   bus    rr_arbiter_mux_if.slave (requests, lock, output channel, i_ready)
// Build option:
//   RR_ARB_LOCK_EN  when defined, a granted requester with i_req_lock=1 keeps
//                   top priority after its transfer (ptr is not rotated).
module rr_arbiter_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned COUNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    rr_arbiter_mux_if.slave  bus
);
    logic [COUNT-1:0] ptr;
    logic [COUNT-1:0] mask;
    logic [COUNT-1:0] high;
    logic [COUNT-1:0] sel;
    logic [COUNT-1:0] rot;
    logic [COUNT-1:0] ptr_next;
    logic [WIDTH-1:0] mux_data;
    logic             acc;

    assign acc = !bus.o_valid || bus.i_ready;

    // Wrapping search from ptr: take the lowest valid bit at or above ptr,
    // otherwise the lowest valid bit overall. ptr is one-hot, so ptr-1 is a
    // mask of the bits below it.
    always_comb begin
        mask = ~(ptr - COUNT'(1));
        high = bus.i_req_valid & mask;
        if (|high) begin
            sel = high & (~high + COUNT'(1));
        end else begin
            sel = bus.i_req_valid & (~bus.i_req_valid + COUNT'(1));
        end
    end

    assign rot = (sel << 1) | (sel >> (COUNT - 1));

`ifdef RR_ARB_LOCK_EN
    assign ptr_next = (|(sel & bus.i_req_lock)) ? sel : rot;
`else
    logic unused_lock;
    assign unused_lock = ^bus.i_req_lock;
    assign ptr_next    = rot;
`endif

    always_comb begin
        mux_data = '0;
        for (int unsigned k = 0; k < COUNT; k++) begin
            mux_data = mux_data | (bus.i_req_data[k] & {WIDTH{sel[k]}});
        end
    end

    assign bus.o_req_ready = (acc && !i_rst) ? sel : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr         <= COUNT'(1);
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_grant <= '0;
        end else if (acc) begin
            bus.o_valid <= |sel;
            bus.o_data  <= mux_data;
            bus.o_grant <= sel;
            if (|sel) begin
                ptr <= ptr_next;
            end
        end
    end
endmodule

// File: tb/tb_rr_arbiter_mux.sv
// tb_rr_arbiter_mux: directed, table-driven bench for rr_arbiter_mux
// (WIDTH=32, COUNT=4, payload of requester k is 0xA0+k).
module tb_rr_arbiter_mux;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter_mux_if #(.WIDTH(32), .COUNT(4)) bus ();

    rr_arbiter_mux #(.WIDTH(32), .COUNT(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        rdy;
        logic [3:0]  rr;
        logic        ov;
        logic [3:0]  gnt;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lk_rr [5];

    initial begin
        for (int k = 0; k < 4; k++) bus.i_req_data[k] = 32'hA0 + k;
        bus.i_req_lock  = '0;
        bus.i_req_valid = 4'hF;
        bus.i_ready     = 1'b1;
        rst             = 1'b1;
        next_cycle();

        //          rst   v     rdy   rr    ov    gnt   dat
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 32'h00};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 4'h0, 32'h00};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 4'h1, 32'hA0};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 4'h2, 32'hA1};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 4'h4, 32'hA2};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 4'h8, 32'hA3};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 4'h1, 32'hA0};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 4'h2, 32'hA1};
        tbl[8]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'h4, 32'hA2};
        tbl[9]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'h4, 32'hA2};
        tbl[10] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'h4, 32'hA2};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 4'h4, 32'hA2};
        tbl[12] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 4'h8, 32'hA3};
        tbl[13] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 4'h1, 32'hA0};
        tbl[14] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 4'h2, 32'hA1};
        tbl[15] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 4'h8, 32'hA3};
        tbl[16] = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 4'h2, 32'hA1};
        tbl[17] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 4'h8, 32'hA3};
        tbl[18] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 4'h2, 32'hA1};
        tbl[19] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h00};

        for (int i = 0; i < 20; i++) begin
            rst             = tbl[i].rst;
            bus.i_req_valid = tbl[i].v;
            bus.i_ready     = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl[%0d] req_ready", i), 32'(bus.o_req_ready), 32'(tbl[i].rr));
            check($sformatf("tbl[%0d] o_valid", i),   32'(bus.o_valid),     32'(tbl[i].ov));
            check($sformatf("tbl[%0d] o_grant", i),   32'(bus.o_grant),     32'(tbl[i].gnt));
            check($sformatf("tbl[%0d] o_data", i),    bus.o_data,           tbl[i].dat);
            next_cycle();
        end

        // Lock sequence: requesters 0 and 1 valid, requester 0 locks for 3 transfers.
`ifdef RR_ARB_LOCK_EN
        lk_rr[0] = 4'h1; lk_rr[1] = 4'h1; lk_rr[2] = 4'h1; lk_rr[3] = 4'h1; lk_rr[4] = 4'h2;
`else
        lk_rr[0] = 4'h1; lk_rr[1] = 4'h2; lk_rr[2] = 4'h1; lk_rr[3] = 4'h2; lk_rr[4] = 4'h1;
`endif
        rst             = 1'b1;
        bus.i_req_valid = 4'h0;
        bus.i_ready     = 1'b1;
        @(negedge clk);
        check("lock reset req_ready", 32'(bus.o_req_ready), 32'h0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.i_req_valid = 4'h3;
            bus.i_req_lock  = (c < 3) ? 4'h1 : 4'h0;
            @(negedge clk);
            check($sformatf("lock[%0d] req_ready", c), 32'(bus.o_req_ready), 32'(lk_rr[c]));
            if (c > 0) begin
                check($sformatf("lock[%0d] o_grant", c), 32'(bus.o_grant), 32'(lk_rr[c-1]));
                check($sformatf("lock[%0d] o_data", c), bus.o_data,
                      (lk_rr[c-1] == 4'h1) ? 32'hA0 : 32'hA1);
            end
            next_cycle();
        end
        bus.i_req_lock = 4'h0;

        // Reset while a payload is stalled: held payload must be discarded.
        bus.i_req_valid = 4'h4;
        bus.i_ready     = 1'b1;
        @(negedge clk);
        check("stall load req_ready", 32'(bus.o_req_ready), 32'h4);
        next_cycle();
        bus.i_ready = 1'b0;
        @(negedge clk);
        check("stall o_valid", 32'(bus.o_valid), 32'h1);
        check("stall o_data", bus.o_data, 32'hA2);
        check("stall req_ready", 32'(bus.o_req_ready), 32'h0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("mid-stall reset req_ready", 32'(bus.o_req_ready), 32'h0);
        next_cycle();
        rst             = 1'b0;
        bus.i_req_valid = 4'hF;
        @(negedge clk);
        check("post-reset o_valid", 32'(bus.o_valid), 32'h0);
        check("post-reset o_data", bus.o_data, 32'h0);
        check("post-reset o_grant", 32'(bus.o_grant), 32'h0);
        check("post-reset ptr req_ready", 32'(bus.o_req_ready), 32'h1);
        next_cycle();
        bus.i_req_valid = 4'h0;
        bus.i_ready     = 1'b1;
        @(negedge clk);
        check("post-reset first o_valid", 32'(bus.o_valid), 32'h1);
        check("post-reset first o_data", bus.o_data, 32'hA0);
        check("post-reset first o_grant", 32'(bus.o_grant), 32'h1);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_mux.md
# rr_arbiter_mux

Round-robin arbiter that shares a single registered output channel among COUNT requesters with valid/ready handshakes. A one-hot grant selects the winning payload with the AND-OR reduction scheme used throughout the library. A one-entry output register decouples the consumer from the requesters. It sits in front of shared resources such as a writeback port, a memory request port or a shared functional unit.

## Interface
- WIDTH, 32, payload width in bits
- COUNT, 4, number of requesters; legal values 1..16
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_req_valid  input  [COUNT-1:0]  requester k has a payload
- i_req_data  input  [WIDTH-1:0] x [0:COUNT-1]  per-requester payload, unpacked array
- i_req_lock  input  [COUNT-1:0]  requester k asks to keep priority after its transfer; only used with RR_ARB_LOCK_EN
- o_req_ready  output  [COUNT-1:0]  one-hot or zero; requester k's payload is accepted this cycle
- o_valid  output  1  output register holds a payload
- o_data  output  [WIDTH-1:0]  output payload
- o_grant  output  [COUNT-1:0]  one-hot ID of the requester whose payload is in o_data
- i_ready  input  1  consumer accepts o_data this cycle

## Operation
- State:
  - ptr: one-hot, highest-priority requester; reset value is bit 0.
  - Output register: o_valid, o_data, o_grant.
- Accept condition: acc = !o_valid | i_ready.
- Grant selection (combinational):
  - Search for the first asserted i_req_valid bit starting at ptr and wrapping from bit COUNT-1 to bit 0. The result sel is one-hot, or zero when no request is valid.
  - COUNT==1: sel = i_req_valid[0].
- o_req_ready = acc ? sel : 0. A requester is considered transferred in a cycle where its i_req_valid and o_req_ready are both 1.
- Payload mux: OR over k of (i_req_data[k] & {WIDTH{sel[k]}}). No priority encoder index is used.
- On the clock edge when acc is true:
  - o_valid <= |sel
  - o_data <= muxed payload
  - o_grant <= sel
  - If sel != 0, ptr <= sel rotated left by 1, wrapping.
- When acc is false, the output register and ptr hold. A stalled payload stays stable, and o_req_ready is all zero.
- If acc is true with no valid request, o_valid clears and o_data/o_grant load zero.
- A requester may deassert i_req_valid or change i_req_data while not granted. A granted request completes in the same cycle, so no requester-side holding rule exists.
- Simultaneous output drain and accept of a new payload (i_ready=1 with a pending request) is legal and gives full throughput of one transfer per cycle.
- Reset takes priority over everything, including mid-stall:
  - o_valid=0, o_data=0, o_grant=0, ptr=bit 0.
  - Any held payload is discarded.
  - o_req_ready is 0 during reset.

## Timing
- Latency: a payload accepted in cycle N appears on o_data/o_valid in cycle N+1.
- Throughput: 1 transfer per cycle when i_ready is held high.
- Fairness: with all COUNT requesters continuously valid and i_ready=1, each requester is granted exactly once in every COUNT consecutive grants.
- Combinational paths: i_ready and i_req_valid to o_req_ready. There is no combinational path from i_req_data to any output.

## Configuration
- RR_ARB_LOCK_EN defined:
  - If the requester in sel has i_req_lock[k]=1, ptr <= sel (not rotated) on transfer. That requester keeps top priority for back-to-back bursts until it transfers with lock=0 or drops valid.
  - The lock state is ptr itself; no extra register.
- RR_ARB_LOCK_EN undefined: i_req_lock is ignored and ptr always rotates after a transfer.

## Test plan
- Reset with all requests high: during i_rst=1, o_valid=0, o_grant=0, o_req_ready=0. In the first cycle after reset, o_req_ready=4'b0001. In the next cycle, o_data=i_req_data[0] and o_grant=4'b0001.
- All four requesters valid, payloads 0xA0..0xA3, i_ready=1 for 8 cycles. Required outputs:
  - Grant order 0,1,2,3,0,1,2,3.
  - o_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0,... starting one cycle after the first grant.
- Backpressure: after requester 2 is accepted, hold i_ready=0 for 3 cycles. Required: o_data=0xA2 and o_valid=1 stable, o_req_ready=0. On the cycle i_ready returns to 1, requester 3 is granted in that same cycle.
- Sparse requests: only requesters 1 and 3 valid, ptr at bit 2. Required grant order 3,1,3,1, with no idle cycles.
- Lock (with RR_ARB_LOCK_EN): requesters 0 and 1 valid, requester 0 holds lock=1 for 3 transfers, then lock=0. Required grant order 0,0,0,0,1. Without the macro, the same stimulus gives 0,1,0,1,0.
- Reset mid-stall: o_valid=1, i_ready=0, then i_rst for 1 cycle. Required: o_valid=0 next cycle and ptr at bit 0; the held payload never appears on the output.
